// File: rtl/cajero_pkg.sv
// cajero_pkg: shared widths and FSM state encoding for the ATM controller
package cajero_pkg;
   localparam int ANCHO_PIN    = 16;
   localparam int ANCHO_DIGITO = 4;
   localparam int ANCHO_MONTO  = 32;
   localparam int MAX_INTENTOS = 3;
   typedef logic [1:0] estado_t;
   localparam estado_t ESPERA_TARJETA = 2'd0;
   localparam estado_t INGRESO_PIN    = 2'd1;
   localparam estado_t ESPERA_MONTO   = 2'd2;
   localparam estado_t BLOQUEADO      = 2'd3;
endpackage

// File: rtl/cajero_controlador_if.sv
// cajero_controlador_if: card, PIN, transaction and result signals of the ATM controller
interface cajero_controlador_if
   import cajero_pkg::*;
#(
   parameter int ANCHO_BALANCE = 64
);
   logic                     tarjeta_recibida;
   logic                     tipo_de_tarjeta;
   logic [ANCHO_PIN-1:0]     pin;
   logic [ANCHO_DIGITO-1:0]  digito;
   logic                     digito_stb;
   logic                     tipo_trans;
   logic [ANCHO_MONTO-1:0]   monto;
   logic                     monto_stb;
   logic                     balance_actualizado;
   logic                     entregar_dinero;
   logic                     fondos_insuficientes;
   logic                     pin_incorrecto;
   logic                     advertencia;
   logic                     bloqueo;
   logic [ANCHO_BALANCE-1:0] balance;
   modport master (
      output tarjeta_recibida, tipo_de_tarjeta, pin, digito, digito_stb, tipo_trans, monto, monto_stb,
      input  balance_actualizado, entregar_dinero, fondos_insuficientes, pin_incorrecto, advertencia, bloqueo, balance
   );
   modport slave (
      input  tarjeta_recibida, tipo_de_tarjeta, pin, digito, digito_stb, tipo_trans, monto, monto_stb,
      output balance_actualizado, entregar_dinero, fondos_insuficientes, pin_incorrecto, advertencia, bloqueo, balance
   );
endinterface

// File: rtl/cajero_verificador_pin.sv
// cajero_verificador_pin: collects 4 PIN digits, compares them and counts failed attempts
module cajero_verificador_pin
   import cajero_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    digito_stb,
   input  logic [ANCHO_DIGITO-1:0] digito,
   input  logic [ANCHO_PIN-1:0]    pin_ref,
   output logic                    pin_ok,
   output logic                    pin_mal,
   output logic [1:0]              intentos
);
   logic [ANCHO_PIN-1:0] registro;
   logic [ANCHO_PIN-1:0] entrada;
   logic [1:0]           cuenta;
   logic                 cuarto;
   // verdict is decided on the edge that accepts the 4th digit, so it is combinational here
   always_comb begin
      entrada = {registro[ANCHO_PIN-ANCHO_DIGITO-1:0], digito};
      cuarto  = digito_stb && cuenta == 2'd3;
      pin_ok  = cuarto && entrada == pin_ref;
      pin_mal = cuarto && entrada != pin_ref;
   end
   // digit shift register; the 2-bit counter wraps to 0 after the 4th digit
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         registro <= '0;
         cuenta   <= '0;
      end else if (clear) begin
         registro <= '0;
         cuenta   <= '0;
      end else if (digito_stb) begin
         registro <= entrada;
         cuenta   <= cuenta + 2'd1;
      end
   // failed attempts survive card removal; only a correct PIN or reset clears them
   always_ff @(posedge clk or posedge reset)
      if (reset)
         intentos <= '0;
      else if (pin_ok)
         intentos <= '0;
      else if (pin_mal)
         intentos <= intentos + 2'd1;
endmodule

// File: rtl/cajero_controlador.sv
// cajero_controlador: ATM session FSM, PIN lockout and balance update; COMISION_EN adds a non-BCR withdrawal fee
module cajero_controlador
   import cajero_pkg::*;
#(
   parameter int                     ANCHO_BALANCE   = 64,
   parameter logic [ANCHO_BALANCE-1:0] BALANCE_INICIAL = 64'd50000,
   parameter logic [31:0]            COMISION        = 32'd500
)(
   input logic                 clk,
   input logic                 reset,
   cajero_controlador_if.slave bus
);
   estado_t                  estado;
   logic [ANCHO_BALANCE-1:0] saldo;
   logic [ANCHO_PIN-1:0]     pin_ref;
   logic                     actualizado, entregar, fondos, incorrecto, advertencia, bloqueo;
   logic                     dig_stb, limpiar, pin_ok, pin_mal;
   logic [1:0]               intentos;
   logic [ANCHO_BALANCE:0]   suma;
   logic [ANCHO_MONTO:0]     costo;
   logic                     alcanza;
`ifdef COMISION_EN
   logic                     tipo_ref;
`endif
   // digits count only while a card is inserted and the PIN is being entered
   always_comb begin
      dig_stb = estado == INGRESO_PIN && bus.tarjeta_recibida && bus.digito_stb;
      limpiar = estado != INGRESO_PIN;
   end
   cajero_verificador_pin u_verificador (
      .clk        (clk),
      .reset      (reset),
      .clear      (limpiar),
      .digito_stb (dig_stb),
      .digito     (bus.digito),
      .pin_ref    (pin_ref),
      .pin_ok     (pin_ok),
      .pin_mal    (pin_mal),
      .intentos   (intentos)
   );
   // deposit sum carries one extra bit for saturation; withdrawal cost never wraps
   always_comb begin
      suma    = {1'b0, saldo} + (ANCHO_BALANCE+1)'(bus.monto);
`ifdef COMISION_EN
      costo   = {1'b0, bus.monto} + (tipo_ref ? (ANCHO_MONTO+1)'(COMISION) : '0);
`else
      costo   = {1'b0, bus.monto};
`endif
      alcanza = ANCHO_BALANCE'(costo) <= saldo;
   end
   // session FSM, balance register and registered result pulses
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         estado      <= ESPERA_TARJETA;
         saldo       <= BALANCE_INICIAL;
         pin_ref     <= '0;
`ifdef COMISION_EN
         tipo_ref    <= 1'b0;
`endif
         actualizado <= 1'b0;
         entregar    <= 1'b0;
         fondos      <= 1'b0;
         incorrecto  <= 1'b0;
         advertencia <= 1'b0;
         bloqueo     <= 1'b0;
      end else begin
         actualizado <= 1'b0;
         entregar    <= 1'b0;
         fondos      <= 1'b0;
         incorrecto  <= pin_mal;
         case (estado)
            ESPERA_TARJETA:
               if (bus.tarjeta_recibida) begin
                  pin_ref  <= bus.pin;
`ifdef COMISION_EN
                  tipo_ref <= bus.tipo_de_tarjeta;
`endif
                  estado   <= INGRESO_PIN;
               end
            INGRESO_PIN:
               if (!bus.tarjeta_recibida)
                  estado <= ESPERA_TARJETA;
               else if (pin_ok) begin
                  advertencia <= 1'b0;
                  estado      <= ESPERA_MONTO;
               end else if (pin_mal) begin
                  if (intentos == 2'(MAX_INTENTOS-2))
                     advertencia <= 1'b1;
                  if (intentos == 2'(MAX_INTENTOS-1)) begin
                     bloqueo <= 1'b1;
                     estado  <= BLOQUEADO;
                  end
               end
            ESPERA_MONTO:
               if (!bus.tarjeta_recibida)
                  estado <= ESPERA_TARJETA;
               else if (bus.monto_stb) begin
                  estado <= ESPERA_TARJETA;
                  if (!bus.tipo_trans) begin
                     saldo       <= suma[ANCHO_BALANCE] ? '1 : suma[ANCHO_BALANCE-1:0];
                     actualizado <= 1'b1;
                  end else if (alcanza) begin
                     saldo       <= saldo - ANCHO_BALANCE'(costo);
                     actualizado <= 1'b1;
                     entregar    <= 1'b1;
                  end else
                     fondos <= 1'b1;
               end
            default: ;
         endcase
      end
   assign bus.balance              = saldo;
   assign bus.balance_actualizado  = actualizado;
   assign bus.entregar_dinero      = entregar;
   assign bus.fondos_insuficientes = fondos;
   assign bus.pin_incorrecto       = incorrecto;
   assign bus.advertencia          = advertencia;
   assign bus.bloqueo              = bloqueo;
endmodule

// File: tb/tb_cajero_controlador.sv
// tb_cajero_controlador: directed and randomized checks of the ATM controller against a session-level model
module tb_cajero_controlador;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   cajero_controlador_if bus();
   cajero_controlador dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   bit          m_sesion, m_auth, m_bloq, m_adv, m_tipo;
   int          m_fallos;
   logic [3:0]  q[$];
   logic [15:0] m_pin;
   logic [63:0] m_bal;
   bit          e_act, e_ent, e_fon, e_mal;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic modelo_reset();
      m_sesion = 0; m_auth = 0; m_bloq = 0; m_adv = 0; m_tipo = 0; m_fallos = 0;
      q.delete(); m_pin = '0; m_bal = 64'd50000;
      e_act = 0; e_ent = 0; e_fon = 0; e_mal = 0;
   endtask

   task automatic modelo_paso();
      logic [15:0] ent;
      logic [64:0] s;
      logic [32:0] c;
      e_act = 0; e_ent = 0; e_fon = 0; e_mal = 0;
      if (m_bloq) return;
      if (!m_sesion) begin
         if (bus.tarjeta_recibida) begin
            m_sesion = 1; m_auth = 0; q.delete();
            m_pin = bus.pin; m_tipo = bus.tipo_de_tarjeta;
         end
      end else if (!bus.tarjeta_recibida)
         m_sesion = 0;
      else if (!m_auth) begin
         if (bus.digito_stb) begin
            q.push_back(bus.digito);
            if (q.size() == 4) begin
               ent = {q[0], q[1], q[2], q[3]};
               q.delete();
               if (ent == m_pin) begin
                  m_auth = 1; m_fallos = 0; m_adv = 0;
               end else begin
                  m_fallos++;
                  e_mal = 1;
                  if (m_fallos == 2) m_adv = 1;
                  if (m_fallos == 3) m_bloq = 1;
               end
            end
         end
      end else if (bus.monto_stb) begin
         m_sesion = 0;
         if (!bus.tipo_trans) begin
            s = {1'b0, m_bal} + 65'(bus.monto);
            m_bal = s[64] ? '1 : s[63:0];
            e_act = 1;
         end else begin
            c = {1'b0, bus.monto};
`ifdef COMISION_EN
            if (m_tipo) c = c + 33'd500;
`endif
            if (64'(c) <= m_bal) begin
               m_bal = m_bal - 64'(c);
               e_act = 1; e_ent = 1;
            end else
               e_fon = 1;
         end
      end
   endtask

   task automatic ciclo();
      if (reset) modelo_reset(); else modelo_paso();
      @(negedge clk);
      check("balance_actualizado", bus.balance_actualizado, e_act);
      check("entregar_dinero", bus.entregar_dinero, e_ent);
      check("fondos_insuficientes", bus.fondos_insuficientes, e_fon);
      check("pin_incorrecto", bus.pin_incorrecto, e_mal);
      check("advertencia", bus.advertencia, m_adv);
      check("bloqueo", bus.bloqueo, m_bloq);
      check("balance", bus.balance, m_bal);
   endtask

   task automatic do_reset();
      reset = 1; bus.digito_stb = 0; bus.monto_stb = 0;
      ciclo();
      reset = 0;
   endtask

   task automatic abrir(input logic [15:0] p, input logic t);
      bus.tarjeta_recibida = 1; bus.pin = p; bus.tipo_de_tarjeta = t;
      ciclo();
   endtask

   task automatic dig(input logic [3:0] d);
      bus.digito_stb = 1; bus.digito = d;
      ciclo();
      bus.digito_stb = 0;
   endtask

   task automatic pin4(input logic [15:0] p);
      for (int k = 0; k < 4; k++) dig(p[15-4*k -: 4]);
   endtask

   task automatic trans(input logic t, input logic [31:0] m);
      bus.monto_stb = 1; bus.tipo_trans = t; bus.monto = m;
      ciclo();
      bus.monto_stb = 0;
   endtask

   initial begin
      logic [15:0] pines [4];
      int pos;
      pines = '{16'h3443, 16'h1234, 16'h0000, 16'h9999};
      bus.tarjeta_recibida = 0; bus.tipo_de_tarjeta = 0; bus.pin = '0; bus.digito = '0;
      bus.digito_stb = 0; bus.tipo_trans = 0; bus.monto = '0; bus.monto_stb = 0;
      do_reset();
      check("reset_balance", bus.balance, 64'd50000);

      abrir(16'h3443, 0); pin4(16'h3443); trans(0, 32'd100);
      check("t1_balance", bus.balance, 64'd50100);
      check("t1_act", bus.balance_actualizado, 1);
      ciclo();
      check("t1_act_one_cycle", bus.balance_actualizado, 0);

      do_reset(); abrir(16'h3443, 0); pin4(16'h3443); trans(1, 32'd9100);
      check("t2_balance", bus.balance, 64'd40900);
      check("t2_entregar", bus.entregar_dinero, 1);

      do_reset(); abrir(16'h3443, 0); pin4(16'h3443); trans(1, 32'd1000000000);
      check("t3_fondos", bus.fondos_insuficientes, 1);
      check("t3_balance", bus.balance, 64'd50000);

      do_reset(); abrir(16'h3443, 0);
      pin4(16'h1234); check("t4_mal1", bus.pin_incorrecto, 1); check("t4_adv1", bus.advertencia, 0);
      pin4(16'h1111); check("t4_adv2", bus.advertencia, 1);
      pin4(16'h0000); check("t4_bloq", bus.bloqueo, 1);
      pin4(16'h3443); trans(0, 32'd100);
      check("t4_bloq_hold", bus.bloqueo, 1); check("t4_balance", bus.balance, 64'd50000);
      do_reset();
      check("t4_rst_bloq", bus.bloqueo, 0); check("t4_rst_adv", bus.advertencia, 0);

      abrir(16'h3443, 0); dig(4'h3); dig(4'h4);
      bus.tarjeta_recibida = 0; ciclo();
      abrir(16'h3443, 0); dig(4'h4); dig(4'h3);
      check("t5_no_mal", bus.pin_incorrecto, 0);
      trans(0, 32'd7);
      check("t5_ignored", bus.balance, 64'd50000);
      dig(4'h3); dig(4'h4);
      check("t5_fresh_digits", bus.pin_incorrecto, 1);
      pin4(16'h3443); trans(0, 32'd1);
      check("t5_balance", bus.balance, 64'd50001);

      abrir(16'h3443, 0); dig(4'h3);
      #2 reset = 1;
      #1 check("async_reset_balance", bus.balance, 64'd50000);
      ciclo();
      reset = 0;

`ifdef COMISION_EN
      do_reset(); abrir(16'h3443, 1); pin4(16'h3443); trans(1, 32'd49600);
      check("t6_fondos", bus.fondos_insuficientes, 1);
      abrir(16'h3443, 1); pin4(16'h3443); trans(1, 32'd49500);
      check("t6_balance", bus.balance, 64'd0);
      check("t6_entregar", bus.entregar_dinero, 1);
`endif

      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         bus.tarjeta_recibida = ($urandom_range(0, 29) != 0);
         if (!m_sesion) begin
            bus.pin = pines[$urandom_range(0, 3)];
            bus.tipo_de_tarjeta = 1'($urandom);
         end
         pos = q.size();
         bus.digito_stb = ($urandom_range(0, 2) != 0);
         bus.digito = ($urandom_range(0, 4) != 0) ? m_pin[15-4*pos -: 4] : 4'($urandom);
         bus.monto_stb = ($urandom_range(0, 3) == 0);
         bus.tipo_trans = 1'($urandom);
         bus.monto = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 60000));
         ciclo();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/cajero_controlador.md
Name: cajero_controlador

Overview:
ATM transaction controller; the device that the ATM testbench drives.
- Accepts a card and collects a 4-digit BCD PIN one strobe at a time.
- Compares the PIN against the card's stored PIN and enforces the 3-attempt lockout.
- Performs a deposit or a withdrawal against an internal balance register, reporting results on single-cycle pulse and level outputs.

Parameters:
BALANCE_INICIAL, 64'd50000, balance value loaded on reset
ANCHO_BALANCE, 64, balance register width
COMISION, 32'd500, withdrawal fee for non-BCR cards (used only with COMISION_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
tarjeta_recibida  input  1  level; card present
tipo_de_tarjeta  input  1  0=BCR card, 1=other bank; sampled at session start
pin  input  16  stored PIN, 4 BCD nibbles, first digit in [15:12]; sampled at session start
digito  input  4  BCD digit being entered
digito_stb  input  1  one-cycle strobe; digito valid
tipo_trans  input  1  0=deposit, 1=withdrawal; sampled with monto_stb
monto  input  32  transaction amount
monto_stb  input  1  one-cycle strobe; monto/tipo_trans valid
balance_actualizado  output  1  one-cycle pulse: balance changed
entregar_dinero  output  1  one-cycle pulse: dispense cash (withdrawal OK)
fondos_insuficientes  output  1  one-cycle pulse: withdrawal rejected
pin_incorrecto  output  1  one-cycle pulse: a wrong PIN was entered
advertencia  output  1  level: 2 failed attempts; cleared on correct PIN or reset
bloqueo  output  1  level: locked after 3 failed attempts; cleared only by reset
balance  output  64  current balance

Behaviour:
- Clocking and reset:
  - One clock domain (clk).
  - reset is asynchronous and active-high.
  - On reset: FSM=ESPERA_TARJETA, balance=BALANCE_INICIAL, attempt counter=0, digit counter=0, digit shift register=0, all pulse/level outputs 0.
- FSM states: ESPERA_TARJETA, INGRESO_PIN, ESPERA_MONTO, BLOQUEADO.
- ESPERA_TARJETA:
  - When tarjeta_recibida=1, latch pin and tipo_de_tarjeta, clear the digit counter, go to INGRESO_PIN.
- INGRESO_PIN:
  - Each edge with digito_stb=1: shift digito into the 16-bit register (new nibble enters [3:0]) and increment the digit counter.
  - Digits 3,4,4,3 therefore produce 'h3443.
  - Values above 9 are accepted and simply mismatch.
  - On the edge that accepts the 4th digit, compare the 16-bit register against the latched pin:
    - Match: clear attempts, clear advertencia, go to ESPERA_MONTO.
    - Mismatch, attempts becomes 1: pin_incorrecto pulses next cycle; stay in INGRESO_PIN with the digit counter cleared.
    - Mismatch, attempts becomes 2: pin_incorrecto pulses and advertencia is set; stay in INGRESO_PIN.
    - Mismatch, attempts becomes 3: pin_incorrecto pulses and bloqueo is set; go to BLOQUEADO.
- ESPERA_MONTO:
  - On an edge with monto_stb=1, deposit (tipo_trans=0): balance += monto, saturating at all-ones; balance_actualizado pulses.
  - On an edge with monto_stb=1, withdrawal (tipo_trans=1):
    - If monto <= balance: balance -= monto; balance_actualizado and entregar_dinero pulse together.
    - Otherwise: fondos_insuficientes pulses and balance is unchanged.
  - After either transaction, return to ESPERA_TARJETA.
- BLOQUEADO:
  - All strobes are ignored; bloqueo stays high until reset.
- Latency: every pulse is registered and is high for exactly the one cycle after the sampling edge.
- Strobes arriving in other states are ignored:
  - digito_stb outside INGRESO_PIN.
  - monto_stb outside ESPERA_MONTO.
- tarjeta_recibida falling to 0 in INGRESO_PIN or ESPERA_MONTO aborts to ESPERA_TARJETA:
  - Balance is unchanged and no pulses are produced.
  - The attempt counter and advertencia are kept, so removing the card cannot dodge the lockout.
- If tarjeta_recibida is still 1 when the FSM returns to ESPERA_TARJETA, a new session starts on the next edge.
- Reset mid-session restores all reset values immediately.

Optional Feature:
COMISION_EN
- Defined, non-BCR card (tipo_de_tarjeta=1):
  - A withdrawal succeeds only if monto+COMISION <= balance, computed at 33+ bits with no wrap.
  - On success, monto+COMISION is subtracted.
  - Deposits and BCR cards are unaffected.
- Undefined: no fee logic is present; the withdrawal compares monto against balance only.

Decomposition:
- Package cajero_pkg holds:
  - The state enum.
  - Width constants: ANCHO_PIN=16, ANCHO_DIGITO=4, ANCHO_MONTO=32, MAX_INTENTOS=3.
- One sub-module is natural: cajero_verificador_pin.
  - Contents: digit shift register, digit counter, comparator and attempt counter.
  - Interface: outputs a one-cycle pin_ok / pin_mal plus an intentos[1:0] count; takes a clear input.

Test Plan:
1. Reset, card BCR, pin='h3443; digits 3,4,4,3; deposit monto=100 -> balance=50100, balance_actualizado pulses one cycle, no other outputs.
2. Correct PIN, withdrawal monto=9100 -> balance=40900; balance_actualizado and entregar_dinero pulse in the same cycle.
3. Correct PIN, withdrawal monto=1000000000 -> fondos_insuficientes pulses; balance stays 50000; entregar_dinero stays 0.
4. Three wrong PINs (1234, 1111, 0000) -> pin_incorrecto pulses 3 times; advertencia=1 after the 2nd; bloqueo=1 after the 3rd; a following correct PIN and monto_stb are ignored; reset clears bloqueo and advertencia.
5. Two digits entered, then tarjeta_recibida=0 -> FSM returns to ESPERA_TARJETA; balance unchanged; the next session needs 4 fresh digits.
6. With COMISION_EN, non-BCR card, balance=50000, withdrawal monto=49600 -> fondos_insuficientes. Withdrawal monto=49500 -> balance=0 and entregar_dinero pulses.
